// File: rtl/div_result_bcd.sv
// rtl/div_result_bcd.sv - parallel double-dabble BCD conversion of divider quotient/remainder
// Optional DIV_BCD_BLANK_EN: leading-zero digits registered as 4'hF for the display decoder.
module div_result_bcd (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  Q,
   input  logic [7:0]  R,
   input  logic        div0,
   output logic        busy,
   output logic        done,
   output logic [11:0] Q_BCD,
   output logic [11:0] R_BCD,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

`ifdef DIV_BCD_BLANK_EN
   localparam logic [11:0] RESULT_RST = 12'hFF0;
`else
   localparam logic [11:0] RESULT_RST = 12'h000;
`endif

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  q_bin_q, q_bin_d, r_bin_q, r_bin_d;
   logic [11:0] q_acc_q, q_acc_d, r_acc_q, r_acc_d;
   logic [11:0] q_bcd_q, q_bcd_d, r_bcd_q, r_bcd_d;
   logic        err_q, err_d;
   logic        err_pend_q, err_pend_d;
   logic        iterating;
   logic        accept;
   logic [19:0] q_shift, r_shift;

   function automatic logic [11:0] add3(input logic [11:0] a);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[i*4 +: 4] = (a[i*4 +: 4] >= 4'd5) ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
      end
      return r;
   endfunction

   function automatic logic [11:0] blank(input logic [11:0] x);
      logic [11:0] r;
      r = x;
`ifdef DIV_BCD_BLANK_EN
      if (x[11:8] == 4'd0) begin
         r[11:8] = 4'hF;
         if (x[7:4] == 4'd0) r[7:4] = 4'hF;
      end
`endif
      return r;
   endfunction

   // cnt reaching 8 marks the registration cycle; a div0 start jumps straight there
   assign iterating = (state_q == S_SHIFT) && !cnt_q[3];
   assign accept    = start && (state_q != S_SHIFT);
   assign q_shift   = {add3(q_acc_q), q_bin_q};
   assign r_shift   = {add3(r_acc_q), r_bin_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         q_bin_q    <= 8'd0;
         r_bin_q    <= 8'd0;
         q_acc_q    <= 12'd0;
         r_acc_q    <= 12'd0;
         q_bcd_q    <= RESULT_RST;
         r_bcd_q    <= RESULT_RST;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         q_bin_q    <= q_bin_d;
         r_bin_q    <= r_bin_d;
         q_acc_q    <= q_acc_d;
         r_acc_q    <= r_acc_d;
         q_bcd_q    <= q_bcd_d;
         r_bcd_q    <= r_bcd_d;
         err_q      <= err_d;
         err_pend_q <= err_pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: state_d = accept ? S_SHIFT : S_IDLE;
         S_SHIFT:        state_d = cnt_q[3] ? S_DONE : S_SHIFT;
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      q_bin_d    = q_bin_q;
      r_bin_d    = r_bin_q;
      q_acc_d    = q_acc_q;
      r_acc_d    = r_acc_q;
      q_bcd_d    = q_bcd_q;
      r_bcd_d    = r_bcd_q;
      err_d      = err_q;
      err_pend_d = err_pend_q;
      if (accept) begin
         q_bin_d    = Q;
         r_bin_d    = R;
         q_acc_d    = 12'd0;
         r_acc_d    = 12'd0;
         cnt_d      = div0 ? 4'd8 : 4'd0;
         err_pend_d = div0;
      end else if (iterating) begin
         q_acc_d = q_shift[18:7];
         r_acc_d = r_shift[18:7];
         q_bin_d = {q_shift[6:0], 1'b0};
         r_bin_d = {r_shift[6:0], 1'b0};
         cnt_d   = cnt_q + 4'd1;
      end else if (state_q == S_SHIFT) begin
         q_bcd_d = blank(q_acc_q);
         r_bcd_d = blank(r_acc_q);
         err_d   = err_pend_q;
      end
   end

   always_comb begin
      busy  = iterating;
      done  = (state_q == S_DONE);
      Q_BCD = q_bcd_q;
      R_BCD = r_bcd_q;
      err   = err_q;
   end

endmodule
